// File: rtl/fir_accumulator_pkg.sv
// Shared FIR datapath types and constants.
//   Partial_product : I/Q pair of 51-bit signed 4.47 multiplier outputs
//   Sum             : I/Q pair of 54-bit signed 7.47 accumulator values
//   Samp            : I/Q pair of 24-bit signed 1.23 output samples
package fir_accumulator_pkg;

  localparam int PP_W      = 51;
  localparam int ACC_W     = 54;
  localparam int SAMP_W    = 24;
  localparam int RND_SHIFT = 24;

  localparam logic [SAMP_W-1:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [SAMP_W-1:0] SAT_MIN = 24'h800000;

  typedef struct packed {
    logic signed [PP_W-1:0] i;
    logic signed [PP_W-1:0] q;
  } Partial_product;

  typedef struct packed {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
  } Sum;

  typedef struct packed {
    logic signed [SAMP_W-1:0] i;
    logic signed [SAMP_W-1:0] q;
  } Samp;

endpackage

// File: rtl/fir_out_fifo.sv
// Circular output buffer for finished samples.
//   Clk, Reset     : clock, asynchronous active-low reset
//   push, din      : write a sample (caller guarantees space)
//   pop            : consume the head sample (ignored when empty)
//   dout           : head sample, straight from registered storage
//   occupancy      : number of stored samples, 0..DEPTH
module fir_out_fifo
  import fir_accumulator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         push,
  input  Samp                          din,
  input  logic                         pop,
  output Samp                          dout,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  Samp              mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (occupancy != '0);
  assign dout   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero when nothing is buffered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fir_accumulator.sv
// Final FIR stage: sums five partial products in a two-stage adder tree,
// rounds/saturates 7.47 to 1.23 and queues samples toward the output port.
//   Clk, Reset          : clock, asynchronous active-low reset
//   count, sp_valid     : controller pass index and "sub-products final" strobe
//   sub_prod_0..4       : partial products (I/Q, 4.47)
//   acc_ready           : a capture would be accepted this cycle
//   out_valid/out_ready : output handshake, out_samp is the FIFO head
//   ovf, ovf_clr        : sticky saturation flag and its clear
module fir_accumulator
  import fir_accumulator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = SAMP_W
) (
  input  logic           Clk,
  input  logic           Reset,
  input  int             count,
  input  logic           sp_valid,
  input  Partial_product sub_prod_0,
  input  Partial_product sub_prod_1,
  input  Partial_product sub_prod_2,
  input  Partial_product sub_prod_3,
  input  Partial_product sub_prod_4,
  output logic           acc_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output Samp            out_samp,
  output logic           ovf,
  input  logic           ovf_clr
);

  localparam int R_W = ACC_W - RND_SHIFT;
  localparam logic signed [ACC_W-1:0] RND_HALF = 54'sd1 <<< (RND_SHIFT - 1);

  function automatic logic signed [ACC_W-1:0] ext(input logic signed [PP_W-1:0] x);
    return {{(ACC_W-PP_W){x[PP_W-1]}}, x};
  endfunction

  function automatic logic signed [R_W-1:0] rnd(input logic signed [ACC_W-1:0] t);
    return R_W'((t + RND_HALF) >>> RND_SHIFT);
  endfunction

  // Fits in OUT_W bits exactly when every bit from the output sign bit up agrees.
  function automatic logic sat_hit(input logic signed [R_W-1:0] r);
    return !(&r[R_W-1:OUT_W-1] || ~|r[R_W-1:OUT_W-1]);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [R_W-1:0] r);
    if (!sat_hit(r)) return r[OUT_W-1:0];
    return r[R_W-1] ? SAT_MIN : SAT_MAX;
  endfunction

  logic                         capture;
  logic                         vld_p1, vld_p2;
  Sum                           a_p1, b_p1, c_p1;
  Sum                           t_p2;
  logic signed [R_W-1:0]        r_i, r_q;
  logic                         sat_any;
  Samp                          wr_samp;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  // Slots already promised to in-flight samples count as used, so a write
  // can never find the FIFO full and the pipeline never needs to stall.
  assign acc_ready = (int'(occupancy) + int'(vld_p1) + int'(vld_p2)) < DEPTH;
  assign capture   = sp_valid && (count == 2) && acc_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      vld_p1 <= capture;
      vld_p2 <= vld_p1;
      if (vld_p2 && sat_any) ovf <= 1'b1;
      else if (ovf_clr)      ovf <= 1'b0;
    end
  end

  // Stage 1: pairwise sums, sign-extended to the 7.47 accumulator width
  always_ff @(posedge Clk) begin
    a_p1.i <= ext(sub_prod_0.i) + ext(sub_prod_1.i);
    a_p1.q <= ext(sub_prod_0.q) + ext(sub_prod_1.q);
    b_p1.i <= ext(sub_prod_2.i) + ext(sub_prod_3.i);
    b_p1.q <= ext(sub_prod_2.q) + ext(sub_prod_3.q);
    c_p1.i <= ext(sub_prod_4.i);
    c_p1.q <= ext(sub_prod_4.q);
  end

  // Stage 2: final sum
  always_ff @(posedge Clk) begin
    t_p2.i <= a_p1.i + b_p1.i + c_p1.i;
    t_p2.q <= a_p1.q + b_p1.q + c_p1.q;
  end

  // Stage 3: round half-up and saturate straight into the FIFO write port
  always_comb begin
    r_i       = rnd(t_p2.i);
    r_q       = rnd(t_p2.q);
    sat_any   = sat_hit(r_i) || sat_hit(r_q);
    wr_samp.i = sat(r_i);
    wr_samp.q = sat(r_q);
  end

  assign out_valid = (occupancy != '0);

  fir_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (vld_p2),
    .din       (wr_samp),
    .pop       (out_ready),
    .dout      (out_samp),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fir_accumulator.sv
module tb_fir_accumulator;
  import fir_accumulator_pkg::*;

  logic           Clk = 1'b0;
  logic           Reset;
  int             count;
  logic           sp_valid;
  Partial_product sp [5];
  logic           acc_ready;
  logic           out_valid;
  logic           out_ready;
  Samp            out_samp;
  logic           ovf;
  logic           ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  fir_accumulator #(.DEPTH(4), .OUT_W(24)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .count      (count),
    .sp_valid   (sp_valid),
    .sub_prod_0 (sp[0]),
    .sub_prod_1 (sp[1]),
    .sub_prod_2 (sp[2]),
    .sub_prod_3 (sp[3]),
    .sub_prod_4 (sp[4]),
    .acc_ready  (acc_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_samp   (out_samp),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_sp();
    for (int k = 0; k < 5; k++) sp[k] = '0;
  endtask

  // Capture whatever is on sp[], then check the 3-cycle latency and the result.
  task automatic run_one(input string tag, input logic [23:0] exp_i, input logic [23:0] exp_q);
    sp_valid = 1'b1;
    count    = 2;
    tick();
    sp_valid = 1'b0;
    count    = 0;
    clear_sp();
    check({tag, "_lat1"}, out_valid, 1'b0);
    tick();
    check({tag, "_lat2"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_i"}, $unsigned(out_samp.i), exp_i);
    check({tag, "_q"}, $unsigned(out_samp.q), exp_q);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    Reset     = 1'b0;
    count     = 0;
    sp_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    clear_sp();
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_samp", out_samp, '0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_acc_ready", acc_ready, 1'b1);
    Reset = 1'b1;
    tick();

    sp[0].i = 51'd1 << 45;
    run_one("single", 24'h200000, 24'h000000);
    check("single_ovf", ovf, 1'b0);

    sp[0].i = 51'd1 << 23;
    run_one("rnd_half_pos", 24'h000001, 24'h000000);
    sp[0].i = -(51'sd1 <<< 23);
    run_one("rnd_half_neg", 24'h000000, 24'h000000);
    sp[0].i = (51'd1 << 23) - 51'd1;
    run_one("rnd_below", 24'h000000, 24'h000000);
    sp[0].q = -(51'sd3 <<< 23);
    run_one("rnd_q_neg", 24'h000000, 24'hFFFFFF);
    check("rnd_ovf", ovf, 1'b0);

    for (int k = 0; k < 5; k++) sp[k].i = 51'd1 << 47;
    run_one("sat_pos", 24'h7FFFFF, 24'h000000);
    check("sat_pos_ovf", ovf, 1'b1);
    for (int k = 0; k < 5; k++) sp[k].q = -(51'sd1 <<< 47);
    run_one("sat_neg", 24'h000000, 24'h800000);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 1'b0);

    sp[0].i  = 51'd5 << 24;
    sp_valid = 1'b1;
    count    = 0;
    tick();
    count = 1;
    tick();
    sp_valid = 1'b0;
    count    = 0;
    clear_sp();
    repeat (4) tick();
    check("gate_empty", out_valid, 1'b0);
    check("gate_ready", acc_ready, 1'b1);

    for (int c = 0; c < 6; c++) begin
      sp[0].i  = 51'(c + 1) << 24;
      sp_valid = 1'b1;
      count    = 2;
      check($sformatf("bp_ready_%0d", c), acc_ready, (c < 4) ? 1'b1 : 1'b0);
      tick();
    end
    sp_valid = 1'b0;
    count    = 0;
    clear_sp();
    tick();
    tick();
    check("bp_full_ready", acc_ready, 1'b0);
    check("bp_full_valid", out_valid, 1'b1);
    check("bp_hold_i", $unsigned(out_samp.i), 24'h000001);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_pop_valid_%0d", j), out_valid, 1'b1);
      check($sformatf("bp_pop_i_%0d", j), $unsigned(out_samp.i), 24'(j + 1));
      tick();
    end
    out_ready = 1'b0;
    check("bp_drained", out_valid, 1'b0);
    check("bp_ready_back", acc_ready, 1'b1);

    for (int k = 0; k < 5; k++) sp[k].i = 51'd1 << 47;
    sp_valid = 1'b1;
    count    = 2;
    tick();
    clear_sp();
    sp[0].i = 51'd2 << 24;
    tick();
    sp_valid = 1'b0;
    tick();
    sp[0].i  = 51'd3 << 24;
    sp_valid = 1'b1;
    tick();
    sp_valid = 1'b0;
    count    = 0;
    clear_sp();
    check("mid_valid", out_valid, 1'b1);
    check("mid_ovf", ovf, 1'b1);
    Reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_samp", out_samp, '0);
    check("mid_rst_ready", acc_ready, 1'b1);
    check("mid_rst_ovf", ovf, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    tick();
    tick();
    check("mid_no_ghost", out_valid, 1'b0);
    sp[0].i = 51'd9 << 24;
    run_one("post_rst", 24'h000009, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
